ctrl_ex: RTL and testbench

- Execute-stage controller for the 16-bit Thumb-subset pipeline.
- Consumes the ID-stage outputs: the registered EX instruction word, the ALU select and the data-memory access cycle count.
- Drives the stall back to IF/ID, the data-memory request, register-file and flag write enables, and branch redirect/flush.
- Closes the stall loop that the ID controller only requests.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/cond_eval.sv | 31 +++
 rtl/ctrl_ex.sv | 118 +++++++++++
 tb/tb_ctrl_ex.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU selects, EX states, condition codes and opcode prefixes shared by ID and EX
package cpu_pkg;
  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_MV_IMM = 3'b001;
  localparam logic [2:0] ALU_MV_REG = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b101;
  typedef enum logic [1:0] {EXEC, MEM, LOAD_WB, SQUASH} ex_state_t;
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [6:0] OP_ADD_IMM3 = 7'b0001110;
  localparam logic [4:0] OP_MOV_IMM  = 5'b00100;
  localparam logic [4:0] OP_CMP_IMM  = 5'b00101;
  localparam logic [7:0] OP_MOV_REG  = 8'b01000110;
  localparam logic [8:0] OP_SUB_SP   = 9'b101100001;
  localparam logic [4:0] OP_LDR_LIT  = 5'b01001;
  localparam logic [4:0] OP_STR_IMM  = 5'b01100;
  localparam logic [4:0] OP_LDR_IMM  = 5'b01101;
  localparam logic [4:0] OP_B        = 5'b11100;
  localparam logic [3:0] OP_BCOND    = 4'b1101;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: ARM condition-code test against NZCV
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;
  // one arm per condition code; 1111 falls to the never-taken default
  always_comb
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !c || z;
      COND_GE: taken = n == v;
      COND_LT: taken = n != v;
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
endmodule

// File: rtl/ctrl_ex.sv
// ctrl_ex: execute-stage controller driving stall, data-memory access, write enables and branch redirect
module ctrl_ex
  import cpu_pkg::*;
#(
  parameter logic [3:0] SP_IDX = 4'd13,
  parameter int         CNT_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_ir_ex,
  input  logic [2:0]  i_alu_sel,
  input  logic [3:0]  i_mem_data_access,
  input  logic [3:0]  i_flags,
  output logic        o_stall,
  output logic [2:0]  o_alu_op,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic        o_rf_we,
  output logic [3:0]  o_rf_waddr,
  output logic        o_flags_we,
  output logic        o_branch_taken,
  output logic        o_flush
);
  ex_state_t state, state_n;
  logic [15:8] ir_l;
  logic [2:0] rt_l;
  logic [2:0] alu_l;
  logic [CNT_W-1:0] cnt;
  logic is_load;
  logic cond_ok, taken, mem_go;
  cond_eval u_cond (
    .cond(i_ir_ex[11:8]),
    .flags(i_flags),
    .taken(cond_ok)
  );
  assign mem_go = |i_mem_data_access;
  assign taken = (i_ir_ex[15:11] == OP_B) || ((i_ir_ex[15:12] == OP_BCOND) && cond_ok);
  // state, latched access context and remaining-cycle counter
  always_ff @(posedge clk)
    if (rst) begin
      state <= EXEC;
      ir_l <= '0;
      rt_l <= '0;
      alu_l <= ALU_MV_IMM;
      cnt <= '0;
      is_load <= 1'b0;
    end else begin
      state <= state_n;
      if (state == EXEC && mem_go) begin
        ir_l <= i_ir_ex[15:8];
        rt_l <= i_ir_ex[2:0];
        alu_l <= i_alu_sel;
        is_load <= (i_ir_ex[15:11] == OP_LDR_IMM) || (i_ir_ex[15:11] == OP_LDR_LIT);
        cnt <= CNT_W'(i_mem_data_access - 4'd1);
      end else if (state == MEM && |cnt)
        cnt <= cnt - 1'b1;
    end
  // next state and all outputs; reset forces everything idle so an open access is dropped
  always_comb begin
    state_n = state;
    o_stall = 1'b0;
    o_alu_op = i_alu_sel;
    o_dmem_req = 1'b0;
    o_dmem_we = 1'b0;
    o_rf_we = 1'b0;
    o_rf_waddr = '0;
    o_flags_we = 1'b0;
    o_branch_taken = 1'b0;
    o_flush = 1'b0;
    if (rst) begin
      o_alu_op = ALU_MV_IMM;
      state_n = EXEC;
    end else
      case (state)
        EXEC:
          if (mem_go) begin
            o_dmem_req = 1'b1;
            o_dmem_we = i_ir_ex[15:11] == OP_STR_IMM;
            o_stall = 1'b1;
            state_n = MEM;
          end else if (taken) begin
            o_branch_taken = 1'b1;
            o_flush = 1'b1;
            state_n = SQUASH;
          end else if (i_ir_ex[15:9] == OP_ADD_IMM3) begin
            o_rf_we = 1'b1;
            o_rf_waddr = {1'b0, i_ir_ex[2:0]};
            o_flags_we = 1'b1;
          end else if (i_ir_ex[15:11] == OP_MOV_IMM) begin
            o_rf_we = 1'b1;
            o_rf_waddr = {1'b0, i_ir_ex[10:8]};
            o_flags_we = 1'b1;
          end else if (i_ir_ex[15:8] == OP_MOV_REG) begin
            o_rf_we = 1'b1;
            o_rf_waddr = {i_ir_ex[7], i_ir_ex[2:0]};
          end else if (i_ir_ex[15:7] == OP_SUB_SP) begin
            o_rf_we = 1'b1;
            o_rf_waddr = SP_IDX;
          end else if (i_ir_ex[15:11] == OP_CMP_IMM)
            o_flags_we = 1'b1;
        MEM: begin
          o_dmem_req = 1'b1;
          o_dmem_we = ir_l[15:11] == OP_STR_IMM;
          o_alu_op = alu_l;
          o_stall = |cnt || is_load;
          state_n = |cnt ? MEM : (is_load ? LOAD_WB : EXEC);
        end
        LOAD_WB: begin
          o_alu_op = alu_l;
          o_rf_we = 1'b1;
          o_rf_waddr = {1'b0, ir_l[15:11] == OP_LDR_IMM ? rt_l : ir_l[10:8]};
          state_n = EXEC;
        end
        SQUASH: state_n = EXEC;
        default: state_n = EXEC;
      endcase
  end
endmodule

// File: tb/tb_ctrl_ex.sv
// tb_ctrl_ex: directed and random instruction streams checked against a transaction-level model
module tb_ctrl_ex;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] ir;
  logic [2:0] alu_sel;
  logic [3:0] n_acc;
  logic [3:0] flags;
  logic stall, dmem_req, dmem_we, rf_we, flags_we, br, flush;
  logic [2:0] alu_op;
  logic [3:0] waddr;
  int total = 0;
  int bad = 0;
  ctrl_ex dut (
    .clk(clk),
    .rst(rst),
    .i_ir_ex(ir),
    .i_alu_sel(alu_sel),
    .i_mem_data_access(n_acc),
    .i_flags(flags),
    .o_stall(stall),
    .o_alu_op(alu_op),
    .o_dmem_req(dmem_req),
    .o_dmem_we(dmem_we),
    .o_rf_we(rf_we),
    .o_rf_waddr(waddr),
    .o_flags_we(flags_we),
    .o_branch_taken(br),
    .o_flush(flush)
  );
  always #5 clk = ~clk;
  // expected output vector: {stall, alu_op, req, we, rf_we, waddr, flags_we, branch, flush}
  function automatic logic [13:0] pk(input logic s, input logic [2:0] a, input logic r, input logic w,
                                     input logic rf, input logic [3:0] wa, input logic f, input logic b, input logic fl);
    return {s, a, r, w, rf, wa, f, b, fl};
  endfunction
  // ARM condition table: pairs of codes share a base test, odd codes invert it
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic nf, zf, cf, vf, r;
    {nf, zf, cf, vf} = f;
    case (c[3:1])
      3'd0: r = zf;
      3'd1: r = cf;
      3'd2: r = nf;
      3'd3: r = vf;
      3'd4: r = cf & ~zf;
      3'd5: r = nf == vf;
      3'd6: r = ~zf & (nf == vf);
      default: r = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return (c[0] && c != 4'hE) ? ~r : r;
  endfunction
  function automatic logic [13:0] exp_exec(input logic [15:0] i, input logic [2:0] a, input logic [3:0] n, input logic [3:0] f);
    if (n != 0) return pk(1, a, 1, i[15:11] == 5'b01100, 0, 0, 0, 0, 0);
    if (i[15:11] == 5'b11100 || (i[15:12] == 4'b1101 && cond_ref(i[11:8], f))) return pk(0, a, 0, 0, 0, 0, 0, 1, 1);
    if (i[15:9] == 7'b0001110) return pk(0, a, 0, 0, 1, {1'b0, i[2:0]}, 1, 0, 0);
    if (i[15:11] == 5'b00100) return pk(0, a, 0, 0, 1, {1'b0, i[10:8]}, 1, 0, 0);
    if (i[15:8] == 8'b01000110) return pk(0, a, 0, 0, 1, {i[7], i[2:0]}, 0, 0, 0);
    if (i[15:7] == 9'b101100001) return pk(0, a, 0, 0, 1, 4'd13, 0, 0, 0);
    if (i[15:11] == 5'b00101) return pk(0, a, 0, 0, 0, 0, 1, 0, 0);
    return pk(0, a, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  // compare observed outputs with expectation; waddr ignored without rf_we, alu_op ignored when care_alu=0
  task automatic chk(input string tag, input logic [13:0] e, input logic care_alu);
    logic [13:0] a, m;
    a = {stall, alu_op, dmem_req, dmem_we, rf_we, waddr, flags_we, br, flush};
    m = 14'h3FFF;
    if (!e[7]) m[6:3] = 4'h0;
    if (!care_alu) m[12:10] = 3'b000;
    total++;
    assert ((a & m) === (e & m))
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, a & m, e & m);
    end
  endtask
  // one instruction from issue in EXEC until the controller is back in EXEC
  task automatic run_insn(input logic [15:0] i, input logic [2:0] a, input logic [3:0] n, input logic [3:0] f);
    logic ld, tk;
    ld = n != 0 && (i[15:11] == 5'b01101 || i[15:11] == 5'b01001);
    tk = n == 0 && (i[15:11] == 5'b11100 || (i[15:12] == 4'b1101 && cond_ref(i[11:8], f)));
    @(negedge clk);
    ir = i; alu_sel = a; n_acc = n; flags = f;
    #1 chk("exec", exp_exec(i, a, n, f), 1'b1);
    for (int k = 1; k <= int'(n); k++) begin
      @(negedge clk);
      ir = 16'($urandom); alu_sel = 3'($urandom); n_acc = 4'($urandom); flags = 4'($urandom);
      #1 chk("mem", pk(k < int'(n) || ld, a, 1, i[15:11] == 5'b01100, 0, 0, 0, 0, 0), 1'b1);
    end
    if (ld) begin
      @(negedge clk);
      ir = 16'($urandom); alu_sel = 3'($urandom); n_acc = 4'($urandom);
      #1 chk("load_wb", pk(0, 0, 0, 0, 1, {1'b0, i[15:11] == 5'b01101 ? i[2:0] : i[10:8]}, 0, 0, 0), 1'b0);
    end
    if (tk) begin
      @(negedge clk);
      ir = 16'h2305; alu_sel = 3'b001; n_acc = 4'd0;
      #1 chk("squash", pk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    end
  endtask
  initial begin
    logic [15:0] ri;
    logic [3:0] rn;
    rst = 1'b1; ir = 16'h0000; alu_sel = 3'b000; n_acc = 4'd0; flags = 4'd0;
    @(negedge clk);
    #1 chk("reset_idle", pk(0, 3'b001, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    ir = 16'h2305; n_acc = 4'd3;
    #1 chk("reset_gated", pk(0, 3'b001, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    @(negedge clk);
    rst = 1'b0; ir = 16'h0000; n_acc = 4'd0;
    #1 chk("after_reset", pk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    run_insn(16'h2305, 3'b001, 4'd0, 4'd0);
    // reset in the middle of an N=3 load
    @(negedge clk);
    ir = 16'h6848; alu_sel = 3'b000; n_acc = 4'd3;
    #1 chk("abort_issue", pk(1, 3'b000, 1, 0, 0, 0, 0, 0, 0), 1'b1);
    @(negedge clk);
    ir = 16'h0000; n_acc = 4'd0;
    #1 chk("abort_mem", pk(1, 3'b000, 1, 0, 0, 0, 0, 0, 0), 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("abort_rst", pk(0, 3'b001, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst = 1'b0;
      #1 chk("abort_after", pk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    end
    run_insn(16'h2305, 3'b001, 4'd0, 4'd0);
    run_insn(16'h6848, 3'b000, 4'd2, 4'd0);
    run_insn(16'h4808, 3'b000, 4'd1, 4'd0);
    run_insn(16'h6008, 3'b000, 4'd2, 4'd0);
    run_insn(16'h2305, 3'b001, 4'd0, 4'd0);
    run_insn(16'h6008, 3'b000, 4'd1, 4'd0);
    run_insn(16'h1C8A, 3'b000, 4'd0, 4'd0);
    run_insn(16'h46C5, 3'b010, 4'd0, 4'd0);
    run_insn(16'hB082, 3'b101, 4'd0, 4'd0);
    run_insn(16'h2D07, 3'b101, 4'd0, 4'd0);
    run_insn(16'hD0FE, 3'b000, 4'd0, 4'b0100);
    run_insn(16'hD0FE, 3'b000, 4'd0, 4'b0000);
    run_insn(16'hE7FE, 3'b000, 4'd0, 4'b0000);
    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 16; f++)
        run_insn({4'b1101, 4'(c), 8'hFE}, 3'b000, 4'd0, 4'(f));
    for (int t = 0; t < 400; t++) begin
      ri = 16'($urandom);
      rn = 4'd0;
      case ($urandom_range(0, 9))
        0: ri = {5'b00100, ri[10:0]};
        1: ri = {7'b0001110, ri[8:0]};
        2: ri = {8'b01000110, ri[7:0]};
        3: ri = {9'b101100001, ri[6:0]};
        4: ri = {5'b00101, ri[10:0]};
        5: begin ri = {5'b01101, ri[10:0]}; rn = 4'($urandom_range(1, 15)); end
        6: begin ri = {5'b01001, ri[10:0]}; rn = 4'($urandom_range(1, 15)); end
        7: begin ri = {5'b01100, ri[10:0]}; rn = 4'($urandom_range(1, 15)); end
        8: ri = {4'b1101, ri[11:0]};
        default: ;
      endcase
      run_insn(ri, 3'($urandom), rn, 4'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
